// File: rtl/acs_survivor.sv
// acs_survivor: add-compare-select and 8-deep survivor registers for the K=3, rate-1/2 (7,5) Viterbi decoder.
// Optional ACS_NORM_EN: subtract 64 from all metrics when they all reach 64; without it, metrics saturate at 127.
module acs_survivor (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        frame_start,
  input  logic [1:0]  sym_in,
  output logic [6:0]  PM_1,
  output logic [6:0]  PM_2,
  output logic [6:0]  PM_3,
  output logic [6:0]  PM_4,
  output logic [31:0] data_out,
  output logic        out_valid
);
  logic [6:0] pm [4];
  logic [7:0] sv [4];
  logic [3:0] cnt, cnt_nxt;
  logic [7:0] base_pm [4];
  logic [6:0] base_sv [4];
  logic [6:0] nxt_pm [4];
  logic [6:0] upd_pm [4];
  logic [7:0] nxt_sv [4];

  function automatic logic [7:0] bm(input logic [1:0] sym, input logic u, input logic s1, input logic s0);
    return {7'd0, sym[1] ^ u ^ s1 ^ s0} + {7'd0, sym[0] ^ u ^ s0};
  endfunction

  // a frame start replaces the registered history with a known zero start state
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      base_pm[i] = frame_start ? (i == 0 ? 8'd0 : 8'd16) : {1'b0, pm[i]};
      base_sv[i] = frame_start ? 7'd0 : sv[i][6:0];
    end
  end

  genvar n;
  for (n = 0; n < 4; n++) begin : g_acs
    localparam logic [1:0] ns = 2'(n);
    logic [7:0] c0, c1, best;
    logic       sel;
    assign c0 = base_pm[{ns[0], 1'b0}] + bm(sym_in, ns[1], ns[0], 1'b0);
    assign c1 = base_pm[{ns[0], 1'b1}] + bm(sym_in, ns[1], ns[0], 1'b1);
    assign sel = c1 < c0;
    assign best = sel ? c1 : c0;
    assign nxt_pm[n] = best > 8'd127 ? 7'd127 : best[6:0];
    assign nxt_sv[n] = {sel ? base_sv[{ns[0], 1'b1}] : base_sv[{ns[0], 1'b0}], ns[1]};
  end

`ifdef ACS_NORM_EN
  logic all_hi;
  assign all_hi = nxt_pm[0][6] & nxt_pm[1][6] & nxt_pm[2][6] & nxt_pm[3][6];
  always_comb begin
    for (int i = 0; i < 4; i++)
      upd_pm[i] = all_hi ? {1'b0, nxt_pm[i][5:0]} : nxt_pm[i];
  end
`else
  assign upd_pm = nxt_pm;
`endif

  assign cnt_nxt = frame_start ? 4'd1 : cnt == 4'd8 ? cnt : cnt + 4'd1;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pm <= '{default: '0};
      sv <= '{default: '0};
      cnt <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid && cnt_nxt == 4'd8;
      if (in_valid) begin
        pm <= upd_pm;
        sv <= nxt_sv;
        cnt <= cnt_nxt;
      end
    end

  assign PM_1 = pm[0];
  assign PM_2 = pm[1];
  assign PM_3 = pm[2];
  assign PM_4 = pm[3];
  assign data_out = {sv[3], sv[2], sv[1], sv[0]};
endmodule
